llki_fir_filter_mc: RTL and testbench
=====================================

Name: llki_fir_filter_mc

Overview:
- Parametrised, multi-channel FIR filter with a built-in logic-locking key path. Successor to the fixed-width, single-channel mock-locked FIR wrapper.
- Stored coefficients are obfuscated: effective coefficient = COEF_LOCKED ^ loaded key. Only the correct key produces the intended impulse response; any other key produces a deterministic but wrong response.
- Sits in the CEP core tier and is driven by an LLKI discrete-slave shim, which supplies a word-serial key stream and load/clear commands.

Parameters:
- N_CH, 2, number of time-multiplexed channels sharing one MAC datapath.
- N_TAPS, 8, taps per channel (>=2).
- DATA_W, 16, signed input sample width.
- COEF_W, 16, signed coefficient width. N_TAPS*COEF_W must be a multiple of 32.
- COEF_LOCKED, 0, packed N_TAPS*COEF_W obfuscated coefficient image. Tap 0 is in the LSBs.
- ACC_W, DATA_W+COEF_W+$clog2(N_TAPS), output width (derived, not overridable).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous reset, active-high.
- key_start  in  1  pulse: begin key load and discard the old key.
- key_clear  in  1  pulse: zero the key and all delay lines.
- key_valid  in  1  key word present.
- key_word  in  32  key word. Word 0 maps to key bits [31:0].
- key_ready  out  1  block accepts key words.
- key_loaded  out  1  full key has been received.
- key_err  out  1  sticky protocol error.
- in_valid  in  1  sample present.
- in_ch  in  $clog2(N_CH)  channel of the sample (values >=N_CH are illegal).
- in_data  in  DATA_W  signed sample.
- in_ready  out  1  sample accepted this cycle.
- out_valid  out  1  result valid, one-cycle pulse.
- out_ch  out  $clog2(N_CH)  channel of the result.
- out_data  out  ACC_W  signed filter output.

Behaviour:
- Reset: state=IDLE, key register=0, all delay lines=0, key_ready=0, key_loaded=0, key_err=0, in_ready=1, out_valid=0, out_ch=0, out_data=0.
- Key FSM states: IDLE, LOAD, UNLOCKED. KEY_WORDS = N_TAPS*COEF_W/32; the word counter is $clog2(KEY_WORDS)+1 bits.
- IDLE:
  - key_start -> LOAD; key register and word counter cleared.
  - key_valid -> set key_err; the word is dropped.
- LOAD:
  - key_ready=1 and in_ready=0.
  - Each key_valid&key_ready writes key_word into slice [cnt] and increments cnt.
  - On the last word -> UNLOCKED, key_loaded=1.
  - key_start in LOAD restarts the load (cnt=0, key=0) without an error.
- UNLOCKED:
  - key_ready=0.
  - An extra key_valid sets key_err; the key is unchanged.
  - key_start -> LOAD and key_loaded=0.
- key_clear in any state: -> IDLE, key=0, delay lines=0, key_loaded=0. key_err is preserved.
  - key_clear has priority over key_start in the same cycle.
- key_err is cleared only by reset.
- Datapath runs in IDLE and UNLOCKED using the current key register. In IDLE the key is 0, so the coefficients are raw COEF_LOCKED (scrambled response). No silent zeroing.
- Per channel, a delay line holds N_TAPS samples. On an accept (in_valid & in_ready & in_ch<N_CH), that channel's line shifts: x[0]=in_data, x[k]=x[k-1]. Other channels are untouched.
- in_ch>=N_CH: the sample is consumed, no shift occurs, no output is produced, and key_err is set.
- Arithmetic: out = sum over k of x[k]*c[k], with c[k] = (COEF_LOCKED ^ key)[k*COEF_W +: COEF_W].
  - All signed, full precision, no saturation.
  - The sum uses the post-shift line (includes the new sample).
- Pipeline:
  - Stage 1 registers the N_TAPS products.
  - Stage 2 registers the adder-tree sum.
  - Latency is exactly 2 cycles from accept to out_valid, with out_ch carried along.
  - Throughput is 1 sample/cycle.
- out_data holds its last value when out_valid=0.
- A key change (start or clear) does not flush samples already in the pipeline. They complete using the key sampled at stage 1.
- Reset mid-operation flushes the pipeline; out_valid=0 the next cycle.

Decomposition:
- Package llki_fir_pkg holds:
  - localparam helpers KEY_WORDS and ACC_W as functions of the parameters;
  - typedef enum logic [1:0] {IDLE, LOAD, UNLOCKED} llki_fir_state_e;
  - KEY_WORD_W = 32.
- One sub-module: llki_key_loader. It owns the FSM, the word counter, the key register, key_ready, key_loaded and key_err, and exports the packed key.
- Delay lines, MAC and pipeline stay in the top module.

Test Plan:
- Reset, then N_TAPS=8, COEF_LOCKED=all 0x0001, key untouched; impulse 0x0100 on ch0 -> eight outputs of 0x100 on ch0, each 2 cycles after its accept.
- Load the key equal to COEF_LOCKED^{taps 1..8} (4 words); impulse 1 on ch1 -> outputs 1,2,...,8. ch0 is not disturbed; an interleaved ch0 impulse yields independent results.
- Send 5 key words in LOAD -> key_loaded after word 4; the 5th sets key_err and leaves the key unchanged; in_ready=0 throughout LOAD.
- Assert key_clear and key_start in the same cycle mid-stream -> state IDLE, delay lines zero, in-flight results still emitted, the next impulse uses the raw COEF_LOCKED response.
- Drive in_data=-32768 on all taps with the unlocked coefficient 0x7FFF -> out_data = -8*32768*32767 exact in ACC_W, no overflow.
- Assert reset with 2 samples in the pipeline -> out_valid=0 from the next cycle, key_loaded=0, key_err=0.

Source files
------------

// File: rtl/llki_fir_pkg.sv
// Shared types and sizing helpers for the LLKI-locked multi-channel FIR filter.
package llki_fir_pkg;

   // Width of one word of the serial key stream.
   localparam int KEY_WORD_W = 32;

   // Key FSM encoding shared by the key loader and the datapath gating.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD     = 2'd1,
      UNLOCKED = 2'd2
   } llki_fir_state_e;

   // Number of key words needed to cover the whole coefficient image.
   function automatic int key_words_f(input int n_taps, input int coef_w);
      return (n_taps * coef_w) / KEY_WORD_W;
   endfunction

   // Full-precision accumulator width: product width plus adder-tree growth.
   function automatic int acc_w_f(input int data_w, input int coef_w, input int n_taps);
      return data_w + coef_w + $clog2(n_taps);
   endfunction

endpackage : llki_fir_pkg

// File: rtl/llki_key_loader.sv
// Key-path controller: word-serial key load FSM, key register and the
// sticky protocol-error flag.
module llki_key_loader
   import llki_fir_pkg::*;
#(
   parameter int KEY_W = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  key_start,
   input  logic                  key_clear,
   input  logic                  key_valid,
   input  logic [KEY_WORD_W-1:0] key_word,
   input  logic                  ch_err,
   output logic [KEY_W-1:0]      key,
   output llki_fir_state_e       state,
   output logic                  key_ready,
   output logic                  key_loaded,
   output logic                  key_err
);

   localparam int KEY_WORDS = KEY_W / KEY_WORD_W;
   localparam int CNT_W     = $clog2(KEY_WORDS) + 1;

   llki_fir_state_e   state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [KEY_W-1:0]  key_q, key_d;
   logic              ready_q, ready_d;
   logic              loaded_q, loaded_d;
   logic              err_q, err_d;

   // Next-state logic for the key FSM, counter, key image and status flags.
   always_comb begin
      // NOTE: every _d starts from its _q value, so no branch leaves a signal
      // unassigned and no latch can be inferred.
      state_d  = state_q;
      cnt_d    = cnt_q;
      key_d    = key_q;
      loaded_d = loaded_q;
      err_d    = err_q | ch_err;

      if (key_clear) begin
         // Clear wins over start; the error history survives.
         state_d  = IDLE;
         cnt_d    = '0;
         key_d    = '0;
         loaded_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (key_valid) begin
                  err_d = 1'b1;
               end
               if (key_start) begin
                  state_d = LOAD;
                  cnt_d   = '0;
                  key_d   = '0;
               end
            end
            LOAD: begin
               if (key_start) begin
                  // Restart the load from word 0 without flagging an error.
                  cnt_d = '0;
                  key_d = '0;
               end else if (key_valid) begin
                  for (int w = 0; w < KEY_WORDS; w++) begin
                     if (cnt_q == CNT_W'(w)) begin
                        key_d[w*KEY_WORD_W +: KEY_WORD_W] = key_word;
                     end
                  end
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(KEY_WORDS - 1)) begin
                     state_d  = UNLOCKED;
                     loaded_d = 1'b1;
                  end
               end
            end
            UNLOCKED: begin
               if (key_valid) begin
                  // Surplus word: flag it, the key stays as loaded.
                  err_d = 1'b1;
               end
               if (key_start) begin
                  state_d  = LOAD;
                  cnt_d    = '0;
                  key_d    = '0;
                  loaded_d = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      ready_d = (state_d == LOAD);
   end

   // Key FSM state register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with <= only; all combinational
      // next-state math uses = inside always_comb.
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         key_q    <= '0;
         ready_q  <= 1'b0;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         ready_q  <= ready_d;
         loaded_q <= loaded_d;
         err_q    <= err_d;
      end
   end

   assign key        = key_q;
   assign state      = state_q;
   assign key_ready  = ready_q;
   assign key_loaded = loaded_q;
   assign key_err    = err_q;

endmodule : llki_key_loader

// File: rtl/llki_fir_filter_mc.sv
// Multi-channel FIR filter whose coefficients are unlocked by an LLKI key.
// Per-channel delay lines feed one shared two-stage MAC pipeline.
module llki_fir_filter_mc
   import llki_fir_pkg::*;
#(
   parameter int                        N_CH        = 2,
   parameter int                        N_TAPS      = 8,
   parameter int                        DATA_W      = 16,
   parameter int                        COEF_W      = 16,
   parameter logic [N_TAPS*COEF_W-1:0]  COEF_LOCKED = '0,
   localparam int                       ACC_W       = acc_w_f(DATA_W, COEF_W, N_TAPS),
   localparam int                       CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     key_start,
   input  logic                     key_clear,
   input  logic                     key_valid,
   input  logic [KEY_WORD_W-1:0]    key_word,
   output logic                     key_ready,
   output logic                     key_loaded,
   output logic                     key_err,
   input  logic                     in_valid,
   input  logic [CH_W-1:0]          in_ch,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [CH_W-1:0]          out_ch,
   output logic signed [ACC_W-1:0]  out_data
);

   localparam int KEY_W  = N_TAPS * COEF_W;
   localparam int PROD_W = DATA_W + COEF_W;

   logic [KEY_W-1:0]  key;
   llki_fir_state_e   state;
   logic              ch_ok;
   logic              accept;
   logic              bad_ch;
   logic [KEY_W-1:0]  coef_eff;

   // Post-shift view of the addressed channel's delay line.
   logic signed [DATA_W-1:0] win [N_TAPS];

   logic signed [DATA_W-1:0] line_q [N_CH][N_TAPS];
   logic signed [DATA_W-1:0] line_d [N_CH][N_TAPS];

   logic                     v1_q, v1_d;
   logic [CH_W-1:0]          ch1_q, ch1_d;
   logic signed [PROD_W-1:0] prod_q [N_TAPS];
   logic signed [PROD_W-1:0] prod_d [N_TAPS];

   logic                     out_valid_q, out_valid_d;
   logic [CH_W-1:0]          out_ch_q, out_ch_d;
   logic signed [ACC_W-1:0]  out_data_q, out_data_d;
   logic signed [ACC_W-1:0]  sum_d;

   llki_key_loader #(
      .KEY_W (KEY_W)
   ) u_key_loader (
      .clk        (clk),
      .reset      (reset),
      .key_start  (key_start),
      .key_clear  (key_clear),
      .key_valid  (key_valid),
      .key_word   (key_word),
      .ch_err     (bad_ch),
      .key        (key),
      .state      (state),
      .key_ready  (key_ready),
      .key_loaded (key_loaded),
      .key_err    (key_err)
   );

   // Samples are refused only while a key is being loaded.
   assign in_ready = (state != LOAD);
   assign accept   = in_valid & in_ready & ch_ok;
   assign bad_ch   = in_valid & in_ready & ~ch_ok;
   assign coef_eff = COEF_LOCKED ^ key;

   // Channel decode, shifted window, per-tap products and delay-line update.
   always_comb begin
      ch_ok = 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
         win[k] = '0;
      end
      win[0] = in_data;
      for (int c = 0; c < N_CH; c++) begin
         if (in_ch == CH_W'(c)) begin
            ch_ok = 1'b1;
            for (int k = 1; k < N_TAPS; k++) begin
               win[k] = line_q[c][k-1];
            end
         end
      end

      for (int k = 0; k < N_TAPS; k++) begin
         prod_d[k] = PROD_W'(win[k]) * PROD_W'($signed(coef_eff[k*COEF_W +: COEF_W]));
      end

      v1_d  = accept;
      ch1_d = in_ch;

      line_d = line_q;
      if (key_clear) begin
         for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < N_TAPS; k++) begin
               line_d[c][k] = '0;
            end
         end
      end else if (accept) begin
         for (int c = 0; c < N_CH; c++) begin
            if (in_ch == CH_W'(c)) begin
               line_d[c] = win;
            end
         end
      end
   end

   // Adder tree over the registered products; output holds between results.
   always_comb begin
      sum_d = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         sum_d = sum_d + ACC_W'(prod_q[k]);
      end
      out_valid_d = v1_q;
      out_ch_d    = v1_q ? ch1_q : out_ch_q;
      out_data_d  = v1_q ? sum_d : out_data_q;
   end

   // Delay lines, pipeline valids and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < N_TAPS; k++) begin
               line_q[c][k] <= '0;
            end
         end
         v1_q        <= 1'b0;
         ch1_q       <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_data_q  <= '0;
      end else begin
         line_q      <= line_d;
         v1_q        <= v1_d;
         ch1_q       <= ch1_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_data_q  <= out_data_d;
      end
   end

   // Stage-1 product registers, qualified downstream by v1_q.
   always_ff @(posedge clk) begin
      // NOTE: the product array has no reset; its contents are only consumed
      // when v1_q is set, and v1_q itself is reset.
      prod_q <= prod_d;
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_data  = out_data_q;

endmodule : llki_fir_filter_mc

// File: tb/tb_llki_fir_filter_mc.sv
// Directed self-checking bench for llki_fir_filter_mc (2 channels, 8 taps,
// COEF_LOCKED = 0x0001 on every tap).
module tb_llki_fir_filter_mc;

   localparam int ACC_W = 35;

   logic               clk = 1'b0;
   logic               reset;
   logic               key_start, key_clear, key_valid;
   logic [31:0]        key_word;
   logic               key_ready, key_loaded, key_err;
   logic               in_valid;
   logic [0:0]         in_ch;
   logic signed [15:0] in_data;
   logic               in_ready;
   logic               out_valid;
   logic [0:0]         out_ch;
   logic signed [ACC_W-1:0] out_data;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   bit    mon_en   = 1'b0;

   // Expected output per cycle index, filled in when a sample is driven.
   bit     exp_v  [4096];
   bit     exp_ch [4096];
   longint exp_d  [4096];

   llki_fir_filter_mc #(
      .N_CH        (2),
      .N_TAPS      (8),
      .DATA_W      (16),
      .COEF_W      (16),
      .COEF_LOCKED ({8{16'h0001}})
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_start  (key_start),
      .key_clear  (key_clear),
      .key_valid  (key_valid),
      .key_word   (key_word),
      .key_ready  (key_ready),
      .key_loaded (key_loaded),
      .key_err    (key_err),
      .in_valid   (in_valid),
      .in_ch      (in_ch),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ch     (out_ch),
      .out_data   (out_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Output monitor: every cycle, out_valid must match the expectation table.
   always @(negedge clk) begin
      if (mon_en) begin
         check("out_valid", out_valid, exp_v[cyc]);
         if (exp_v[cyc]) begin
            check("out_ch", out_ch, exp_ch[cyc]);
            check("out_data", out_data, exp_d[cyc]);
         end
      end
   end

   // One clock of stimulus; a valid sample books its result two cycles on.
   task automatic drive(input logic ks, input logic kc, input logic kv,
                        input logic [31:0] kw, input logic iv, input logic ich,
                        input logic signed [15:0] d, input longint e);
      @(posedge clk);
      #1;
      key_start = ks;
      key_clear = kc;
      key_valid = kv;
      key_word  = kw;
      in_valid  = iv;
      in_ch     = ich;
      in_data   = d;
      if (iv) begin
         exp_v[cyc+2]  = 1'b1;
         exp_ch[cyc+2] = ich;
         exp_d[cyc+2]  = e;
      end
   endtask

   task automatic sample(input logic ch, input logic signed [15:0] d, input longint e);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, ch, d, e);
   endtask

   task automatic kword(input logic [31:0] w);
      drive(1'b0, 1'b0, 1'b1, w, 1'b0, 1'b0, 16'sh0, 0);
   endtask

   task automatic kstart();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'sh0, 0);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'sh0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      longint ramp [8];
      ramp = '{1, 3, 6, 10, 15, 21, 28, 36};

      reset     = 1'b1;
      key_start = 1'b0;
      key_clear = 1'b0;
      key_valid = 1'b0;
      key_word  = 32'h0;
      in_valid  = 1'b0;
      in_ch     = 1'b0;
      in_data   = 16'sh0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state.
      check("rst_key_ready", key_ready, 0);
      check("rst_key_loaded", key_loaded, 0);
      check("rst_key_err", key_err, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_out_data", out_data, 0);
      mon_en = 1'b1;

      // Locked response: impulse 0x100 on ch0 with raw coefficients of 1.
      sample(1'b0, 16'sh0100, 256);
      for (int i = 0; i < 7; i++) sample(1'b0, 16'sh0, 256);
      sample(1'b0, 16'sh0, 0);

      // Load key giving taps 1..8: per-tap key = 0x0001 ^ (k+1).
      kstart();
      kword(32'h0003_0000);
      kword(32'h0005_0002);
      kword(32'h0007_0004);
      kword(32'h0009_0006);
      idle();
      check("load1_key_loaded", key_loaded, 1);
      check("load1_key_err", key_err, 0);
      check("load1_in_ready", in_ready, 1);

      // Interleaved impulses: ch1 impulse 1 -> 1..8, ch0 impulse 2 -> 2..16.
      for (int i = 0; i < 8; i++) begin
         sample(1'b1, (i == 0) ? 16'sh1 : 16'sh0, longint'(i + 1));
         sample(1'b0, (i == 0) ? 16'sh2 : 16'sh0, longint'(2 * (i + 1)));
      end

      // Five words in LOAD: fifth is surplus and must not change the key.
      kstart();
      kword(32'h0003_0000);
      check("load2_key_ready", key_ready, 1);
      check("load2_in_ready_w0", in_ready, 0);
      kword(32'h0005_0002);
      check("load2_in_ready_w1", in_ready, 0);
      kword(32'h0007_0004);
      check("load2_in_ready_w2", in_ready, 0);
      kword(32'h0009_0006);
      check("load2_not_loaded_early", key_loaded, 0);
      kword(32'hDEAD_BEEF);
      check("load2_key_loaded", key_loaded, 1);
      check("load2_key_ready_off", key_ready, 0);
      check("load2_err_before_extra", key_err, 0);
      idle();
      check("load2_err_after_extra", key_err, 1);
      check("load2_still_loaded", key_loaded, 1);

      // Step of ones on ch1 walks the prefix sums of 1..8: key intact.
      for (int i = 0; i < 8; i++) sample(1'b1, 16'sh1, ramp[i]);

      // Clear + start together mid-stream; in-flight results still appear.
      sample(1'b0, 16'sh1, 1);
      sample(1'b0, 16'sh1, 3);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'sh0, 0);
      idle();
      check("clr_key_loaded", key_loaded, 0);
      check("clr_key_ready", key_ready, 0);
      check("clr_in_ready", in_ready, 1);
      check("clr_key_err_kept", key_err, 1);
      // Cleared lines and raw coefficients of 1.
      sample(1'b1, 16'sh5, 5);
      sample(1'b1, 16'sh0, 5);
      sample(1'b0, 16'sh0, 0);

      // Unlock 0x7FFF on every tap and drive full-scale negative samples.
      kstart();
      for (int w = 0; w < 4; w++) kword(32'h7FFE_7FFE);
      idle();
      check("load3_key_loaded", key_loaded, 1);
      for (int k = 1; k <= 8; k++) begin
         sample(1'b0, 16'sh8000, -longint'(k) * 32768 * 32767);
      end
      idle();
      idle();

      // Reset with two samples in flight: the second result must never show.
      sample(1'b1, 16'sh1, 6 * 32767);
      sample(1'b1, 16'sh0, 6 * 32767);
      @(posedge clk);
      #1;
      reset    = 1'b1;
      in_valid = 1'b0;
      exp_v[cyc+1] = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("prst_out_valid", out_valid, 0);
      check("prst_key_loaded", key_loaded, 0);
      check("prst_key_err", key_err, 0);
      check("prst_out_ch", out_ch, 0);
      check("prst_out_data", out_data, 0);
      check("prst_in_ready", in_ready, 1);

      // Key word while IDLE is a protocol error.
      kword(32'h1234_5678);
      idle();
      check("idle_word_err", key_err, 1);
      check("idle_word_not_loaded", key_loaded, 0);

      // Delay lines were zeroed by reset; key is zero again.
      sample(1'b1, 16'sh1, 1);
      sample(1'b0, 16'sh0, 0);
      repeat (4) idle();
      mon_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_llki_fir_filter_mc
